// File: rtl/rgb_pwm_driver_if.sv
// Signal bundle between the color source / LED pins and rgb_pwm_driver.
// The master side supplies color, brightness and enable; the slave side drives the LED channels and status.
interface rgb_pwm_driver_if;
  logic [3:0] color;
  logic [1:0] brightness;
  logic       enable;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       period_start;
  logic [3:0] active_color;

  modport master (
    output color, brightness, enable,
    input  led_r, led_g, led_b, period_start, active_color
  );

  modport slave (
    input  color, brightness, enable,
    output led_r, led_g, led_b, period_start, active_color
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver with a fixed 16-entry color palette and shift dimming.
// Color and brightness are latched only at PWM period boundaries, so outputs never glitch mid-period.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  rgb_pwm_driver_if.slave  bus
);

  localparam int unsigned          PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0]  PWM_LAST = '1;

  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } rgb_t;

  // Palette entries are 8-bit intensities; codes 10..15 are deliberately dark.
  function automatic rgb_t palette(input logic [3:0] code);
    rgb_t c;
    c = '0;
    case (code)
      4'd1:    c = '{r: PWM_BITS'(255), g: PWM_BITS'(255), b: PWM_BITS'(255)};
      4'd2:    c = '{r: PWM_BITS'(255), g: PWM_BITS'(0),   b: PWM_BITS'(0)};
      4'd3:    c = '{r: PWM_BITS'(0),   g: PWM_BITS'(255), b: PWM_BITS'(0)};
      4'd4:    c = '{r: PWM_BITS'(0),   g: PWM_BITS'(0),   b: PWM_BITS'(255)};
      4'd5:    c = '{r: PWM_BITS'(255), g: PWM_BITS'(255), b: PWM_BITS'(0)};
      4'd6:    c = '{r: PWM_BITS'(0),   g: PWM_BITS'(255), b: PWM_BITS'(255)};
      4'd7:    c = '{r: PWM_BITS'(255), g: PWM_BITS'(0),   b: PWM_BITS'(255)};
      4'd8:    c = '{r: PWM_BITS'(255), g: PWM_BITS'(64),  b: PWM_BITS'(0)};
      4'd9:    c = '{r: PWM_BITS'(128), g: PWM_BITS'(0),   b: PWM_BITS'(255)};
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                first_q, first_d;
  logic [3:0]          active_color_q, active_color_d;
  rgb_t                duty_q, duty_d;
  logic                led_r_q, led_r_d;
  logic                led_g_q, led_g_d;
  logic                led_b_q, led_b_d;
  logic                period_start_q, period_start_d;

  logic tick;
  logic boundary;
  rgb_t pal;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned and infers a latch.
    pre_cnt_d      = pre_cnt_q;
    pwm_cnt_d      = pwm_cnt_q;
    first_d        = first_q;
    active_color_d = active_color_q;
    duty_d         = duty_q;
    period_start_d = 1'b0;

    tick     = (pre_cnt_q == PRE_LAST);
    boundary = (tick && (pwm_cnt_q == PWM_LAST)) || first_q;
    pal      = palette(bus.color);

    if (tick) begin
      pre_cnt_d = '0;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end

    if (boundary) begin
      active_color_d = bus.color;
      duty_d.r       = pal.r >> bus.brightness;
      duty_d.g       = pal.g >> bus.brightness;
      duty_d.b       = pal.b >> bus.brightness;
      first_d        = 1'b0;
      period_start_d = 1'b1;
    end

    // Compare against the pre-edge duty so a new color shows from the cycle after its boundary.
    led_r_d = bus.enable && (pwm_cnt_q < duty_q.r);
    led_g_d = bus.enable && (pwm_cnt_q < duty_q.g);
    led_b_d = bus.enable && (pwm_cnt_q < duty_q.b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      first_q        <= 1'b1;
      active_color_q <= '0;
      duty_q         <= '0;
      led_r_q        <= 1'b0;
      led_g_q        <= 1'b0;
      led_b_q        <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values, independent of statement order.
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      first_q        <= first_d;
      active_color_q <= active_color_d;
      duty_q         <= duty_d;
      led_r_q        <= led_r_d;
      led_g_q        <= led_g_d;
      led_b_q        <= led_b_d;
      period_start_q <= period_start_d;
    end
  end

  assign bus.led_r        = led_r_q;
  assign bus.led_g        = led_g_q;
  assign bus.led_b        = led_b_q;
  assign bus.period_start = period_start_q;
  assign bus.active_color = active_color_q;

endmodule
